// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified RAM port: CPU (requester 0) and loader/debug (requester 1).
// Runs the MFA/MOC handshake, checks alignment, enforces a MOC timeout and returns data with a done pulse.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  main_clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_rw,
  input  logic [1:0]            cpu_size,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_done,
  output logic                  cpu_err,
  input  logic                  ldr_req,
  input  logic                  ldr_rw,
  input  logic [1:0]            ldr_size,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic [DATA_WIDTH-1:0] ldr_rdata,
  output logic                  ldr_done,
  output logic                  ldr_err,
  output logic                  ram_mfa,
  output logic                  ram_rw,
  output logic [1:0]            ram_size,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  ram_moc,
  output logic [1:0]            grant,
  output logic                  busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

  // Reserved size, or halfword/word not on its natural boundary.
  function automatic logic access_fault(input logic [1:0] size, input logic [1:0] low_addr);
    logic fault;
    case (size)
      2'b00:   fault = 1'b0;
      2'b01:   fault = low_addr[0];
      2'b10:   fault = (low_addr != 2'b00);
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

  state_t                state_r;
  logic                  owner_r;       // 0 = CPU, 1 = loader
  logic                  last_owner_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  ram_mfa_r;
  logic                  ram_rw_r;
  logic [1:0]            ram_size_r;
  logic [ADDR_WIDTH-1:0] ram_addr_r;
  logic [DATA_WIDTH-1:0] ram_wdata_r;
  logic [1:0]            grant_r;
  logic                  busy_r;
  logic [DATA_WIDTH-1:0] cpu_rdata_r;
  logic                  cpu_done_r;
  logic                  cpu_err_r;
  logic [DATA_WIDTH-1:0] ldr_rdata_r;
  logic                  ldr_done_r;
  logic                  ldr_err_r;

  logic                  pick_valid_s;
  logic                  pick_ldr_s;
  logic                  sel_rw_s;
  logic [1:0]            sel_size_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic                  sel_fault_s;

  // Round-robin pick between pending requesters and mux of the winner's command.
  always_comb begin
    pick_valid_s = cpu_req | ldr_req;
    if (cpu_req && ldr_req) begin
      pick_ldr_s = ~last_owner_r;
    end else if (ldr_req) begin
      pick_ldr_s = 1'b1;
    end else begin
      pick_ldr_s = 1'b0;
    end
    if (pick_ldr_s) begin
      sel_rw_s    = ldr_rw;
      sel_size_s  = ldr_size;
      sel_addr_s  = ldr_addr;
      sel_wdata_s = ldr_wdata;
    end else begin
      sel_rw_s    = cpu_rw;
      sel_size_s  = cpu_size;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
    end
    sel_fault_s = access_fault(sel_size_s, sel_addr_s[1:0]);
  end

  // Access sequencer: grant, RAM handshake with timeout, one-cycle completion.
  always_ff @(posedge main_clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
      cnt_r        <= {CNT_W{1'b0}};
      ram_mfa_r    <= 1'b0;
      ram_rw_r     <= 1'b1;
      ram_size_r   <= 2'b00;
      ram_addr_r   <= {ADDR_WIDTH{1'b0}};
      ram_wdata_r  <= {DATA_WIDTH{1'b0}};
      grant_r      <= 2'b00;
      busy_r       <= 1'b0;
      cpu_rdata_r  <= {DATA_WIDTH{1'b0}};
      cpu_done_r   <= 1'b0;
      cpu_err_r    <= 1'b0;
      ldr_rdata_r  <= {DATA_WIDTH{1'b0}};
      ldr_done_r   <= 1'b0;
      ldr_err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            owner_r     <= pick_ldr_s;
            ram_rw_r    <= sel_rw_s;
            ram_size_r  <= sel_size_s;
            ram_addr_r  <= sel_addr_s;
            ram_wdata_r <= sel_wdata_s;
            grant_r     <= pick_ldr_s ? 2'b10 : 2'b01;
            busy_r      <= 1'b1;
            if (sel_fault_s) begin
              // Rejected before any bus cycle: done/err go out immediately.
              state_r <= ST_COMPLETE;
              if (pick_ldr_s) begin
                ldr_done_r  <= 1'b1;
                ldr_err_r   <= 1'b1;
                ldr_rdata_r <= {DATA_WIDTH{1'b0}};
              end else begin
                cpu_done_r  <= 1'b1;
                cpu_err_r   <= 1'b1;
                cpu_rdata_r <= {DATA_WIDTH{1'b0}};
              end
            end else begin
              state_r   <= ST_WAIT;
              ram_mfa_r <= 1'b1;
              cnt_r     <= {CNT_W{1'b0}};
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (ram_moc) begin
            ram_mfa_r <= 1'b0;
            state_r   <= ST_COMPLETE;
            if (owner_r) begin
              ldr_done_r <= 1'b1;
              ldr_err_r  <= 1'b0;
              if (ram_rw_r) begin
                ldr_rdata_r <= ram_rdata;
              end else begin
                ldr_rdata_r <= ldr_rdata_r;
              end
            end else begin
              cpu_done_r <= 1'b1;
              cpu_err_r  <= 1'b0;
              if (ram_rw_r) begin
                cpu_rdata_r <= ram_rdata;
              end else begin
                cpu_rdata_r <= cpu_rdata_r;
              end
            end
          end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
            ram_mfa_r <= 1'b0;
            state_r   <= ST_COMPLETE;
            if (owner_r) begin
              ldr_done_r  <= 1'b1;
              ldr_err_r   <= 1'b1;
              ldr_rdata_r <= {DATA_WIDTH{1'b0}};
            end else begin
              cpu_done_r  <= 1'b1;
              cpu_err_r   <= 1'b1;
              cpu_rdata_r <= {DATA_WIDTH{1'b0}};
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_COMPLETE: begin
          cpu_done_r   <= 1'b0;
          cpu_err_r    <= 1'b0;
          ldr_done_r   <= 1'b0;
          ldr_err_r    <= 1'b0;
          last_owner_r <= owner_r;
          grant_r      <= 2'b00;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          ram_mfa_r <= 1'b0;
          grant_r   <= 2'b00;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign ram_mfa   = ram_mfa_r;
  assign ram_rw    = ram_rw_r;
  assign ram_size  = ram_size_r;
  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;
  assign grant     = grant_r;
  assign busy      = busy_r;
  assign cpu_rdata = cpu_rdata_r;
  assign cpu_done  = cpu_done_r;
  assign cpu_err   = cpu_err_r;
  assign ldr_rdata = ldr_rdata_r;
  assign ldr_done  = ldr_done_r;
  assign ldr_err   = ldr_err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a big-endian byte RAM model whose MOC delay is programmable.
module tb_mem_port_arbiter;

  logic        main_clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_rw, ldr_req, ldr_rw;
  logic [1:0]  cpu_size, ldr_size, ram_size, grant;
  logic [8:0]  cpu_addr, ldr_addr, ram_addr;
  logic [31:0] cpu_wdata, ldr_wdata, cpu_rdata, ldr_rdata, ram_wdata, ram_rdata;
  logic        cpu_done, cpu_err, ldr_done, ldr_err, ram_mfa, ram_rw, ram_moc, busy;

  int checks = 0;
  int errors = 0;
  int moc_delay = 0;
  int wait_cnt = 0;
  int mfa_cnt = 0;
  int cpu_done_cnt = 0;
  logic [7:0] mem [0:511];

  always #5 main_clk = ~main_clk;

  mem_port_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .TIMEOUT(15)) dut (
    .main_clk(main_clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .ldr_req(ldr_req), .ldr_rw(ldr_rw), .ldr_size(ldr_size), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_rdata(ldr_rdata), .ldr_done(ldr_done), .ldr_err(ldr_err),
    .ram_mfa(ram_mfa), .ram_rw(ram_rw), .ram_size(ram_size), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_moc(ram_moc),
    .grant(grant), .busy(busy)
  );

  // RAM model: MOC rises moc_delay cycles after MFA is first sampled.
  assign ram_moc = ram_mfa && (wait_cnt >= moc_delay);

  always @(posedge main_clk) begin
    wait_cnt     <= (ram_mfa === 1'b1) ? wait_cnt + 1 : 0;
    mfa_cnt      <= mfa_cnt + ((ram_mfa === 1'b1) ? 1 : 0);
    cpu_done_cnt <= cpu_done_cnt + ((cpu_done === 1'b1) ? 1 : 0);
    if (ram_mfa === 1'b1 && ram_moc && ram_rw === 1'b0) begin
      case (ram_size)
        2'b00: mem[ram_addr] <= ram_wdata[7:0];
        2'b01: begin
          mem[ram_addr]        <= ram_wdata[15:8];
          mem[ram_addr + 9'd1] <= ram_wdata[7:0];
        end
        default: begin
          mem[ram_addr]        <= ram_wdata[31:24];
          mem[ram_addr + 9'd1] <= ram_wdata[23:16];
          mem[ram_addr + 9'd2] <= ram_wdata[15:8];
          mem[ram_addr + 9'd3] <= ram_wdata[7:0];
        end
      endcase
    end
  end

  always_comb begin
    case (ram_size)
      2'b00:   ram_rdata = {24'h0, mem[ram_addr]};
      2'b01:   ram_rdata = {16'h0, mem[ram_addr], mem[ram_addr + 9'd1]};
      default: ram_rdata = {mem[ram_addr], mem[ram_addr + 9'd1], mem[ram_addr + 9'd2], mem[ram_addr + 9'd3]};
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge main_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One access; n is the tick (1 = first edge after req) on which done is seen, 0 if never.
  task automatic access(input logic who, input logic rw, input logic [1:0] size, input logic [8:0] addr,
                        input logic [31:0] wd, input logic keep, output int n, output logic [31:0] rd,
                        output logic er, output logic [1:0] g1);
    if (who) begin
      ldr_req = 1'b1; ldr_rw = rw; ldr_size = size; ldr_addr = addr; ldr_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_rw = rw; cpu_size = size; cpu_addr = addr; cpu_wdata = wd;
    end
    n = 0; rd = 32'h0; er = 1'b0; g1 = 2'b00;
    for (int i = 1; i <= 200; i++) begin
      tick;
      if (i == 1) g1 = grant;
      if ((who ? ldr_done : cpu_done) === 1'b1) begin
        n  = i;
        rd = who ? ldr_rdata : cpu_rdata;
        er = who ? ldr_err : cpu_err;
        break;
      end
    end
    if (!keep) begin
      if (who) ldr_req = 1'b0;
      else     cpu_req = 1'b0;
    end
  endtask

  initial begin
    int n;
    int m0;
    int d0;
    int bad_lat;
    int bad_mem;
    logic [31:0] rd;
    logic er;
    logic [1:0] g1;

    reset = 1'b0;
    cpu_req = 1'b0; cpu_rw = 1'b1; cpu_size = 2'b00; cpu_addr = 9'h0; cpu_wdata = 32'h0;
    ldr_req = 1'b0; ldr_rw = 1'b1; ldr_size = 2'b00; ldr_addr = 9'h0; ldr_wdata = 32'h0;
    tick; tick;
    reset = 1'b1;
    check("rst_grant", {30'h0, grant}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_mfa", {31'h0, ram_mfa}, 32'h0);
    check("rst_ram_rw", {31'h0, ram_rw}, 32'h1);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_ldr_done", {31'h0, ldr_done}, 32'h0);

    // Loader preloads the word at 0x010, zero-wait RAM.
    moc_delay = 0;
    access(1'b1, 1'b0, 2'b10, 9'h010, 32'hE3A01005, 1'b0, n, rd, er, g1);
    check("ldr_pre_lat", n, 32'd2);
    check("ldr_pre_grant", {30'h0, g1}, 32'h2);
    tick;

    // CPU word read, MOC two cycles after MFA.
    moc_delay = 2;
    m0 = mfa_cnt;
    access(1'b0, 1'b1, 2'b10, 9'h010, 32'h0, 1'b0, n, rd, er, g1);
    check("cpu_rd_lat", n, 32'd4);
    check("cpu_rd_data", rd, 32'hE3A01005);
    check("cpu_rd_err", {31'h0, er}, 32'h0);
    check("cpu_rd_grant", {30'h0, g1}, 32'h1);
    check("cpu_rd_mfa_cycles", mfa_cnt - m0, 32'd3);
    tick;

    // Misaligned loader halfword write: immediate error, no bus cycle.
    m0 = mfa_cnt;
    access(1'b1, 1'b0, 2'b01, 9'h003, 32'h1234, 1'b0, n, rd, er, g1);
    check("ldr_mis_lat", n, 32'd1);
    check("ldr_mis_err", {31'h0, er}, 32'h1);
    tick;
    check("ldr_mis_no_mfa", mfa_cnt - m0, 32'd0);
    check("cpu_rdata_untouched", cpu_rdata, 32'hE3A01005);

    // Reserved size from the CPU.
    access(1'b0, 1'b1, 2'b11, 9'h000, 32'h0, 1'b0, n, rd, er, g1);
    check("cpu_rsv_lat", n, 32'd1);
    check("cpu_rsv_err", {31'h0, er}, 32'h1);
    tick;

    // Loader word write with one wait state, then CPU reads it back.
    moc_delay = 1;
    access(1'b1, 1'b0, 2'b10, 9'h004, 32'hDEADBEEF, 1'b0, n, rd, er, g1);
    check("ldr_wr_lat", n, 32'd3);
    check("ldr_wr_err", {31'h0, er}, 32'h0);
    check("ram_bytes_4_7", {mem[4], mem[5], mem[6], mem[7]}, 32'hDEADBEEF);
    tick;
    moc_delay = 0;
    access(1'b0, 1'b1, 2'b10, 9'h004, 32'h0, 1'b0, n, rd, er, g1);
    check("cpu_rdback", rd, 32'hDEADBEEF);
    tick;

    // Reset during WAIT abandons the access.
    moc_delay = 1000;
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_size = 2'b10; cpu_addr = 9'h010;
    tick; tick;
    check("wait_mfa", {31'h0, ram_mfa}, 32'h1);
    d0 = cpu_done_cnt;
    reset = 1'b0;
    tick;
    check("rstw_mfa", {31'h0, ram_mfa}, 32'h0);
    check("rstw_grant", {30'h0, grant}, 32'h0);
    check("rstw_busy", {31'h0, busy}, 32'h0);
    cpu_req = 1'b0;
    reset = 1'b1;
    tick;
    check("rstw_no_done", cpu_done_cnt - d0, 32'd0);

    // Simultaneous requests: CPU, idle gap, loader, then CPU wins the next tie.
    moc_delay = 0;
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_size = 2'b10; cpu_addr = 9'h004;
    ldr_req = 1'b1; ldr_rw = 1'b1; ldr_size = 2'b00; ldr_addr = 9'h010;
    tick;
    check("tie1_grant", {30'h0, grant}, 32'h1);
    tick;
    check("tie1_cpu_done", {31'h0, cpu_done}, 32'h1);
    check("tie1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    check("tie1_ldr_done", {31'h0, ldr_done}, 32'h0);
    cpu_req = 1'b0;
    tick;
    check("tie_gap_grant", {30'h0, grant}, 32'h0);
    check("tie_gap_busy", {31'h0, busy}, 32'h0);
    tick;
    check("tie2_grant", {30'h0, grant}, 32'h2);
    tick;
    check("tie2_ldr_done", {31'h0, ldr_done}, 32'h1);
    check("tie2_ldr_rdata", ldr_rdata, 32'h000000E3);
    cpu_req = 1'b1; cpu_size = 2'b01; cpu_addr = 9'h012;
    tick; tick;
    check("tie3_grant", {30'h0, grant}, 32'h1);
    tick;
    check("tie3_cpu_rdata", cpu_rdata, 32'h00001005);
    cpu_req = 1'b0; ldr_req = 1'b0;
    tick;

    // MOC never arrives: timeout after 15 MFA cycles.
    moc_delay = 1000;
    m0 = mfa_cnt;
    access(1'b0, 1'b1, 2'b10, 9'h010, 32'h0, 1'b0, n, rd, er, g1);
    check("to_lat", n, 32'd16);
    check("to_mfa_cycles", mfa_cnt - m0, 32'd15);
    check("to_err", {31'h0, er}, 32'h1);
    check("to_rdata", rd, 32'h0);
    check("to_busy_in_complete", {31'h0, busy}, 32'h1);
    tick;
    check("to_busy_falls", {31'h0, busy}, 32'h0);

    // 64 back-to-back loader byte writes, zero-wait RAM.
    moc_delay = 0;
    bad_lat = 0;
    for (int i = 0; i < 64; i++) begin
      access(1'b1, 1'b0, 2'b00, 9'(i), 32'(i ^ 8'hA5), (i != 63), n, rd, er, g1);
      if (n != ((i == 0) ? 2 : 3) || er !== 1'b0) bad_lat++;
    end
    tick;
    check("b2b_latency_errs", bad_lat, 32'd0);
    bad_mem = 0;
    for (int i = 0; i < 64; i++) begin
      if (mem[i] !== 8'(i ^ 8'hA5)) bad_mem++;
    end
    check("b2b_mem_errs", bad_mem, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single unified RAM port between two requesters.
- Requester 0 is the CPU data path (instruction fetch and load/store). Requester 1 is the loader/debug port, which precharges or dumps memory through real bus cycles instead of hierarchical writes.
- Drives the RAM's MFA/MOC handshake, checks alignment, enforces a MOC timeout and returns read data with a one-cycle done pulse.

Parameters:
- ADDR_WIDTH, 9, RAM byte-address width (512 bytes).
- DATA_WIDTH, 32, data bus width.
- TIMEOUT, 15, WAIT cycles without MOC before a bus error.

Ports:
- main_clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU access request; held high until cpu_done.
- cpu_rw  in  1  1=read, 0=write.
- cpu_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (error).
- cpu_addr  in  ADDR_WIDTH  byte address.
- cpu_wdata  in  DATA_WIDTH  write data, right-justified.
- cpu_rdata  out  DATA_WIDTH  read data, valid in the cpu_done cycle and held until next CPU grant.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  high with cpu_done on misalign, reserved size or timeout.
- ldr_req, ldr_rw, ldr_size, ldr_addr, ldr_wdata, ldr_rdata, ldr_done, ldr_err: same widths and meanings for the loader.
- ram_mfa  out  1  memory function activate.
- ram_rw  out  1  to RAM.
- ram_size  out  2  to RAM.
- ram_addr  out  ADDR_WIDTH  to RAM.
- ram_wdata  out  DATA_WIDTH  to RAM.
- ram_rdata  in  DATA_WIDTH  from RAM.
- ram_moc  in  1  memory operation complete.
- grant  out  2  one-hot current owner: bit0 CPU, bit1 loader; 00 when idle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a rising edge):
  - State goes to IDLE.
  - ram_mfa, grant, busy, done and err all 0.
  - rdata outputs 0; ram_* bus 0, with ram_rw=1.
  - last_owner=loader, so the CPU wins the first tie.
  - Reset overrides any state; an in-flight access is abandoned with no done pulse, and ram_mfa is low from the next edge.
- FSM states are IDLE, WAIT, COMPLETE.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not last_owner (round-robin).
  - On grant, latch that requester's rw/size/addr/wdata onto ram_* and set grant and busy.
  - If size==11, or halfword with addr[0]!=0, or word with addr[1:0]!=0, go to COMPLETE with error set. No RAM cycle occurs and ram_mfa stays 0.
  - Otherwise assert ram_mfa, clear the timeout counter and go to WAIT.
- WAIT:
  - ram_mfa is held high and the ram_* bus is stable.
  - When ram_moc==1 is sampled: if read, capture ram_rdata into the owner's rdata. Then drop ram_mfa and go to COMPLETE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no MOC, drop ram_mfa, set error, force owner rdata=0 and go to COMPLETE.
- COMPLETE (one cycle):
  - Owner's done=1; err=error.
  - last_owner=owner.
  - grant cleared; next state IDLE.
  - Requests are re-evaluated only in IDLE, so there is at least one idle cycle between accesses.
- Latency, counting req first seen high in IDLE at edge T:
  - ram_mfa is high from T+1.
  - If MOC is first sampled high at edge T+1+k, done is high for the cycle after that edge.
  - With a zero-wait RAM (MOC already high at T+1), done is visible in cycle T+2.
  - An error access is granted at T and has done+err at T+1.
- Write data is byte/halfword right-justified; the RAM handles lane placement.
- rdata for a byte/halfword read is passed through unmodified; sign/zero extension is the data path's job.
- req dropped before done: the access still runs to completion and done still pulses; there is no abort.
- The non-owner's done, err and rdata are untouched during another requester's access.
- MOC high while in IDLE or COMPLETE is ignored.

Test Plan:
- CPU word read, addr 0x010, RAM holds 0xE3A01005, MOC 2 cycles after MFA -> ram_mfa high 3 cycles; cpu_rdata=0xE3A01005 with cpu_done; cpu_err=0; grant=01 during the access.
- cpu_req and ldr_req rise on the same edge after reset -> CPU served first, then one idle cycle, then loader; a third simultaneous tie goes to the CPU again.
- Loader halfword write at addr 0x003 -> ldr_done=ldr_err=1 at T+1; ram_mfa never asserted. Loader word write at 0x004, wdata 0xDEADBEEF -> RAM location 4..7 = DE AD BE EF.
- MOC held low (TIMEOUT=15) -> ram_mfa high exactly 15 cycles, then cpu_done=cpu_err=1 and cpu_rdata=0; busy falls the next cycle.
- reset driven low during WAIT -> next edge ram_mfa=0, grant=00, no done pulse; a new request after reset is served normally.
- Zero-wait RAM, 64 back-to-back loader byte writes (addresses 0..63) -> each completes in 3 cycles; memory contents match the stimulus.
